// File: rtl/cache_pkg.sv
// Shared types and geometry for the direct-mapped data cache.
// The byte address is split as {tag, index, offset}.
package cache_pkg;
  localparam int ADDR_BITS  = 8;
  localparam int IDX_BITS   = 3;
  localparam int OFF_BITS   = 2;
  localparam int TAG_BITS   = ADDR_BITS - IDX_BITS - OFF_BITS;
  localparam int BLOCK_BITS = 32;
  localparam int NUM_BLOCKS = 1 << IDX_BITS;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WRITEBACK = 2'd1,
    FETCH     = 2'd2
  } state_e;

  typedef struct packed {
    logic [TAG_BITS-1:0] tag;
    logic [IDX_BITS-1:0] idx;
    logic [OFF_BITS-1:0] off;
  } addr_t;

  function automatic addr_t split_addr(input logic [ADDR_BITS-1:0] a);
    return addr_t'(a);
  endfunction
endpackage

// File: rtl/data_cache_if.sv
// CPU-side and memory-side buses of the data cache.
// The cache is the slave on the CPU bus and the master on the memory bus.
interface dc_cpu_if;
  logic       READ;
  logic       WRITE;
  logic [7:0] ADDRESS;
  logic [7:0] WRITEDATA;
  logic [7:0] READDATA;
  logic       BUSYWAIT;

  modport master (output READ, WRITE, ADDRESS, WRITEDATA, input READDATA, BUSYWAIT);
  modport slave  (input READ, WRITE, ADDRESS, WRITEDATA, output READDATA, BUSYWAIT);
endinterface

interface dc_mem_if;
  logic        MEM_READ;
  logic        MEM_WRITE;
  logic [5:0]  MEM_ADDRESS;
  logic [31:0] MEM_WRITEDATA;
  logic [31:0] MEM_READDATA;
  logic        MEM_BUSYWAIT;

  modport master (output MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                  input MEM_READDATA, MEM_BUSYWAIT);
  modport slave  (input MEM_READ, MEM_WRITE, MEM_ADDRESS, MEM_WRITEDATA,
                  output MEM_READDATA, MEM_BUSYWAIT);
endinterface

// File: rtl/dcache_storage.sv
// Line storage: valid/dirty/tag/data arrays with async read, sync byte write
// and line fill, and a sync active-low clear of the valid and dirty bits.
module dcache_storage
  import cache_pkg::*;
#(
  parameter int INDEX_BITS  = IDX_BITS,
  parameter int OFFSET_BITS = OFF_BITS,
  parameter int TAG_W       = TAG_BITS
) (
  input  logic                  i_clk,
  input  logic                  i_rst_n,
  input  logic [INDEX_BITS-1:0] i_idx,
  input  logic [OFFSET_BITS-1:0] i_off,
  input  logic                  i_byte_we,
  input  logic [7:0]            i_byte,
  input  logic                  i_fill_we,
  input  logic [TAG_W-1:0]      i_fill_tag,
  input  logic [BLOCK_BITS-1:0] i_fill_data,
  output logic                  o_valid,
  output logic                  o_dirty,
  output logic [TAG_W-1:0]      o_tag,
  output logic [BLOCK_BITS-1:0] o_data
);
  localparam int N = 1 << INDEX_BITS;

  logic [N-1:0]          r_valid;
  logic [N-1:0]          r_dirty;
  logic [TAG_W-1:0]      r_tag  [N];
  logic [BLOCK_BITS-1:0] r_data [N];

  assign o_valid = r_valid[i_idx];
  assign o_dirty = r_dirty[i_idx];
  assign o_tag   = r_tag[i_idx];
  assign o_data  = r_data[i_idx];

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_valid <= '0;
      r_dirty <= '0;
    end else if (i_fill_we) begin
      r_valid[i_idx] <= 1'b1;
      r_dirty[i_idx] <= 1'b0;
    end else if (i_byte_we) begin
      r_dirty[i_idx] <= 1'b1;
    end
  end

  // Tag/data need no reset; a write in a reset cycle is dropped.
  always_ff @(posedge i_clk) begin
    if (i_rst_n && i_fill_we) begin
      r_tag[i_idx]  <= i_fill_tag;
      r_data[i_idx] <= i_fill_data;
    end else if (i_rst_n && i_byte_we) begin
      r_data[i_idx][{i_off, 3'b000} +: 8] <= i_byte;
    end
  end
endmodule

// File: rtl/data_cache.sv
// Direct-mapped write-back write-allocate data cache: hit logic and the
// IDLE/WRITEBACK/FETCH miss FSM in front of a block-wide memory port.
module data_cache
  import cache_pkg::*;
#(
  parameter int INDEX_BITS  = IDX_BITS,
  parameter int OFFSET_BITS = OFF_BITS
) (
  input logic       CLK,
  input logic       RESET,
  dc_cpu_if.slave   cpu,
  dc_mem_if.master  mem
);
  state_e                r_state, w_next;
  addr_t                 w_a;
  logic                  w_req, w_hit, w_valid, w_dirty;
  logic                  w_byte_we, w_fill_we;
  logic [TAG_BITS-1:0]   w_tag;
  logic [BLOCK_BITS-1:0] w_line;
  logic [7:0]            w_byte;

  assign w_a    = split_addr(cpu.ADDRESS);
  assign w_req  = cpu.READ | cpu.WRITE;
  assign w_hit  = w_valid & (w_tag == w_a.tag);
  assign w_byte = w_line[{w_a.off, 3'b000} +: 8];

  dcache_storage #(
    .INDEX_BITS  (INDEX_BITS),
    .OFFSET_BITS (OFFSET_BITS),
    .TAG_W       (TAG_BITS)
  ) u_store (
    .i_clk       (CLK),
    .i_rst_n     (RESET),
    .i_idx       (w_a.idx),
    .i_off       (w_a.off),
    .i_byte_we   (w_byte_we),
    .i_byte      (cpu.WRITEDATA),
    .i_fill_we   (w_fill_we),
    .i_fill_tag  (w_a.tag),
    .i_fill_data (mem.MEM_READDATA),
    .o_valid     (w_valid),
    .o_dirty     (w_dirty),
    .o_tag       (w_tag),
    .o_data      (w_line)
  );

  always_ff @(posedge CLK) begin
    if (!RESET) r_state <= IDLE;
    else        r_state <= w_next;
  end

  // Strobes depend only on state, so reset drops them on the very next cycle.
  always_comb begin
    w_next            = r_state;
    w_byte_we         = 1'b0;
    w_fill_we         = 1'b0;
    mem.MEM_READ      = 1'b0;
    mem.MEM_WRITE     = 1'b0;
    mem.MEM_ADDRESS   = {w_a.tag, w_a.idx};
    mem.MEM_WRITEDATA = w_line;
    cpu.BUSYWAIT      = w_req;
    cpu.READDATA      = 8'h00;
    unique case (r_state)
      IDLE: begin
        if (w_req && w_hit) begin
          cpu.BUSYWAIT = 1'b0;
          w_byte_we    = cpu.WRITE;
          cpu.READDATA = (cpu.READ && !cpu.WRITE) ? w_byte : 8'h00;
        end else if (w_req) begin
          w_next = w_dirty ? WRITEBACK : FETCH;
        end
      end
      WRITEBACK: begin
        mem.MEM_WRITE   = 1'b1;
        mem.MEM_ADDRESS = {w_tag, w_a.idx};
        if (!mem.MEM_BUSYWAIT) w_next = FETCH;
      end
      FETCH: begin
        mem.MEM_READ = 1'b1;
        if (!mem.MEM_BUSYWAIT) begin
          w_fill_we = 1'b1;
          w_next    = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end
endmodule

// File: tb/tb_data_cache.sv
// Directed bench for data_cache: 5-busy-cycle block memory model, per-access
// stall/strobe capture and hand-computed expected values.
module tb_data_cache;
  localparam int MEM_LAT = 5;

  logic CLK = 1'b0;
  logic RESET;
  always #5 CLK = ~CLK;

  dc_cpu_if cpu ();
  dc_mem_if mem ();

  data_cache dut (
    .CLK   (CLK),
    .RESET (RESET),
    .cpu   (cpu),
    .mem   (mem)
  );

  function automatic logic [31:0] mem_word(input logic [5:0] a);
    case (a)
      6'h01:   return 32'hDDCCBBAA;
      6'h03:   return 32'h87654321;
      6'h04:   return 32'h0BADBEEF;
      6'h09:   return 32'h44332211;
      6'h0B:   return 32'hCAFEF00D;
      default: return 32'h0;
    endcase
  endfunction

  int  mcnt = 0;
  wire mstb = mem.MEM_READ | mem.MEM_WRITE;
  assign mem.MEM_BUSYWAIT = mstb && (mcnt < MEM_LAT);
  assign mem.MEM_READDATA = mem_word(mem.MEM_ADDRESS);

  always @(posedge CLK) begin
    if (!mstb || !mem.MEM_BUSYWAIT) mcnt <= 0;
    else                            mcnt <= mcnt + 1;
  end

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  int          st_cyc, rd_cyc, wr_cyc;
  logic [5:0]  rd_addr, wr_addr;
  logic [31:0] wr_data;
  logic        bad_stab, bad_order, bad_both;

  // Presents one access and waits (bounded) for the cycle where BUSYWAIT drops;
  // returns at the falling edge of that hit cycle.
  task automatic run_acc(input logic rd, input logic wr, input logic [7:0] a, input logic [7:0] d);
    logic done;
    @(posedge CLK); #1;
    cpu.READ = rd; cpu.WRITE = wr; cpu.ADDRESS = a; cpu.WRITEDATA = d;
    st_cyc = 0; rd_cyc = 0; wr_cyc = 0; rd_addr = '0; wr_addr = '0; wr_data = '0;
    bad_stab = 1'b0; bad_order = 1'b0; bad_both = 1'b0; done = 1'b0;
    for (int k = 0; k < 60; k++) begin
      @(negedge CLK);
      if (!cpu.BUSYWAIT) begin done = 1'b1; break; end
      st_cyc++;
      if (mem.MEM_READ && mem.MEM_WRITE) bad_both = 1'b1;
      if (mem.MEM_READ) begin
        if (rd_cyc == 0) rd_addr = mem.MEM_ADDRESS;
        else if (mem.MEM_ADDRESS != rd_addr) bad_stab = 1'b1;
        rd_cyc++;
      end
      if (mem.MEM_WRITE) begin
        if (rd_cyc != 0) bad_order = 1'b1;
        if (wr_cyc == 0) begin wr_addr = mem.MEM_ADDRESS; wr_data = mem.MEM_WRITEDATA; end
        else if (mem.MEM_ADDRESS != wr_addr || mem.MEM_WRITEDATA != wr_data) bad_stab = 1'b1;
        wr_cyc++;
      end
    end
    chk("done", {31'd0, done}, 32'd1);
    chk("strobe_stable", {29'd0, bad_stab, bad_order, bad_both}, 32'd0);
  endtask

  task automatic idle();
    @(posedge CLK); #1;
    cpu.READ = 1'b0; cpu.WRITE = 1'b0;
  endtask

  initial begin
    RESET = 1'b0; cpu.READ = 1'b0; cpu.WRITE = 1'b0; cpu.ADDRESS = '0; cpu.WRITEDATA = '0;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b1;
    @(negedge CLK);
    chk("rst_busy", {31'd0, cpu.BUSYWAIT}, 32'd0);
    chk("rst_rdata", {24'd0, cpu.READDATA}, 32'd0);
    chk("rst_mstb", {30'd0, mem.MEM_READ, mem.MEM_WRITE}, 32'd0);

    // clean read miss on line 1
    run_acc(1'b1, 1'b0, 8'h05, 8'h00);
    chk("rm_stall", st_cyc, 32'd7);
    chk("rm_rdcyc", rd_cyc, 32'd6);
    chk("rm_wrcyc", wr_cyc, 32'd0);
    chk("rm_addr", {26'd0, rd_addr}, 32'h01);
    chk("rm_data", {24'd0, cpu.READDATA}, 32'hBB);
    chk("rm_hit_mstb", {30'd0, mem.MEM_READ, mem.MEM_WRITE}, 32'd0);

    // write hit then read hit
    run_acc(1'b0, 1'b1, 8'h06, 8'h5A);
    chk("wh_stall", st_cyc, 32'd0);
    run_acc(1'b1, 1'b0, 8'h06, 8'h00);
    chk("rh_stall", st_cyc, 32'd0);
    chk("rh_data", {24'd0, cpu.READDATA}, 32'h5A);

    // dirty eviction of line 1
    run_acc(1'b1, 1'b0, 8'h25, 8'h00);
    chk("ev_stall", st_cyc, 32'd13);
    chk("ev_wrcyc", wr_cyc, 32'd6);
    chk("ev_wraddr", {26'd0, wr_addr}, 32'h01);
    chk("ev_wrdata", wr_data, 32'hDD5ABBAA);
    chk("ev_rdaddr", {26'd0, rd_addr}, 32'h09);
    chk("ev_data", {24'd0, cpu.READDATA}, 32'h22);

    // write miss on clean line 3, merged into byte 0
    run_acc(1'b0, 1'b1, 8'h0C, 8'h77);
    chk("wm_stall", st_cyc, 32'd7);
    chk("wm_rdaddr", {26'd0, rd_addr}, 32'h03);
    chk("wm_wrcyc", wr_cyc, 32'd0);
    run_acc(1'b1, 1'b0, 8'h0C, 8'h00);
    chk("wm_rd_stall", st_cyc, 32'd0);
    chk("wm_rd_data", {24'd0, cpu.READDATA}, 32'h77);
    run_acc(1'b1, 1'b0, 8'h2C, 8'h00);
    chk("wm_ev_wrdata", wr_data, 32'h87654377);
    chk("wm_ev_wraddr", {26'd0, wr_addr}, 32'h03);
    chk("wm_ev_rdaddr", {26'd0, rd_addr}, 32'h0B);
    chk("wm_ev_data", {24'd0, cpu.READDATA}, 32'h0D);

    // dirty line 3 again; reset must discard it
    run_acc(1'b0, 1'b1, 8'h2C, 8'h99);
    chk("d3_stall", st_cyc, 32'd0);

    // reset in the middle of a fetch
    @(posedge CLK); #1;
    cpu.READ = 1'b1; cpu.WRITE = 1'b0; cpu.ADDRESS = 8'h10;
    repeat (3) @(negedge CLK);
    chk("rf_mread_pre", {31'd0, mem.MEM_READ}, 32'd1);
    @(posedge CLK); #1 RESET = 1'b0;
    @(negedge CLK);
    @(negedge CLK);
    chk("rf_mstb_post", {30'd0, mem.MEM_READ, mem.MEM_WRITE}, 32'd0);
    chk("rf_busy_post", {31'd0, cpu.BUSYWAIT}, 32'd1);
    @(posedge CLK); #1;
    RESET = 1'b1; cpu.READ = 1'b0;
    @(negedge CLK);
    chk("rf_idle_busy", {31'd0, cpu.BUSYWAIT}, 32'd0);
    chk("rf_idle_rdata", {24'd0, cpu.READDATA}, 32'd0);
    run_acc(1'b1, 1'b0, 8'h10, 8'h00);
    chk("rf_re_stall", st_cyc, 32'd7);
    chk("rf_re_data", {24'd0, cpu.READDATA}, 32'hEF);
    run_acc(1'b1, 1'b0, 8'h2C, 8'h00);
    chk("rf_disc_stall", st_cyc, 32'd7);
    chk("rf_disc_wrcyc", wr_cyc, 32'd0);
    chk("rf_disc_data", {24'd0, cpu.READDATA}, 32'h0D);

    // READ and WRITE together on a hit act as a store
    run_acc(1'b1, 1'b1, 8'h11, 8'h3C);
    chk("rw_stall", st_cyc, 32'd0);
    chk("rw_rdata", {24'd0, cpu.READDATA}, 32'h00);
    run_acc(1'b1, 1'b0, 8'h11, 8'h00);
    chk("rw_rd_data", {24'd0, cpu.READDATA}, 32'h3C);
    run_acc(1'b1, 1'b0, 8'h13, 8'h00);
    chk("rw_rd_b3", {24'd0, cpu.READDATA}, 32'h0B);
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
